// File: rtl/pipe_in_test_seq_pkg.sv
// Shared definitions for the Pipe In data-check sequencer: run states and
// the layout of the 4-bit host status word {aborted, timeout, pass, done}.
package pipe_in_test_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int STAT_DONE    = 0;
  localparam int STAT_PASS    = 1;
  localparam int STAT_TIMEOUT = 2;
  localparam int STAT_ABORTED = 3;
  localparam int STAT_W       = 4;

  typedef struct packed {
    logic aborted;
    logic timeout;
    logic pass;
    logic done;
  } status_t;

endpackage

// File: rtl/pipe_in_test_seq.sv
// Pipe In data-check sequencer. Holds the checker in reset while a run is
// armed, loads its configuration, counts accepted pipe writes up to the
// programmed target and latches the checker's error count and the run status
// for the host once the run has drained.
module pipe_in_test_seq
  import pipe_in_test_seq_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TMO_W   = 24,
  parameter int RST_CYC = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [2:0]       cfg_pattern,
  input  logic [31:0]      cfg_fixed,
  input  logic [31:0]      cfg_throttle,
  input  logic [CNT_W-1:0] cfg_words,
  input  logic [TMO_W-1:0] cfg_timeout,
  input  logic             pipe_in_write,
  input  logic [31:0]      chk_error_count,
  output logic             chk_reset,
  output logic             chk_throttle_set,
  output logic [2:0]       chk_pattern,
  output logic [31:0]      chk_fixed,
  output logic [31:0]      chk_throttle,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic             aborted,
  output logic [CNT_W-1:0] words_seen,
  output logic [31:0]      errors
);

  localparam int ARM_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(RST_CYC - 1);
  localparam logic [ARM_W-1:0] ARM_ONE  = ARM_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [TMO_W-1:0] TMO_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};

  state_t           state;
  state_t           state_nx;
  logic [ARM_W-1:0] arm_cnt;
  logic             drain_cnt;
  logic [CNT_W-1:0] target;
  logic [TMO_W-1:0] tmo_limit;
  logic [TMO_W-1:0] idle_cnt;
  status_t          stat;

  logic             start_ok;
  logic             abort_ok;
  logic             arm_last;
  logic             drain_last;
  logic             final_hit;
  logic             tmo_hit;
  logic [CNT_W-1:0] words_inc;
  logic [TMO_W-1:0] idle_inc;

  assign done    = stat.done;
  assign pass    = stat.pass;
  assign timeout = stat.timeout;
  assign aborted = stat.aborted;

  // Qualified events: which triggers are honoured in the current state, and
  // the saturating increments plus the end-of-run conditions seen in RUN.
  // A write in the cycle the idle limit would be reached counts as activity.
  always_comb begin
    start_ok   = start && (state == IDLE || state == DONE);
    abort_ok   = abort && (state == ARM || state == RUN || state == DRAIN);
    words_inc  = (&words_seen) ? words_seen : words_seen + CNT_ONE;
    idle_inc   = (&idle_cnt) ? idle_cnt : idle_cnt + TMO_ONE;
    arm_last   = (state == ARM) && (arm_cnt == ARM_LAST);
    drain_last = (state == DRAIN) && drain_cnt;
    final_hit  = (state == RUN) && pipe_in_write && (words_seen == target - CNT_ONE);
    tmo_hit    = (state == RUN) && !pipe_in_write && (tmo_limit != '0) &&
                 (idle_inc == tmo_limit);
  end

  // State register; reset drops straight back to IDLE from any state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state decode and the state-derived checker controls. Abort wins over
  // the final-word and timeout events because it is tested first.
  always_comb begin
    state_nx         = state;
    chk_reset        = 1'b0;
    chk_throttle_set = 1'b0;
    busy             = 1'b0;
    case (state)
      IDLE: begin
        chk_reset = 1'b1;
        if (start_ok) state_nx = ARM;
      end
      ARM: begin
        chk_reset        = 1'b1;
        busy             = 1'b1;
        chk_throttle_set = arm_last;
        if (abort_ok)      state_nx = DRAIN;
        else if (arm_last) state_nx = (target == '0) ? DRAIN : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (abort_ok || final_hit || tmo_hit) state_nx = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (!abort_ok && drain_last) state_nx = DONE;
      end
      DONE: begin
        if (start_ok) state_nx = ARM;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Run datapath: configuration capture on start, ARM/DRAIN cycle counters,
  // word and idle counters, and the status latched on entry to DONE. An abort
  // during DRAIN restarts the drain window so the error count settles again.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chk_pattern  <= '0;
      chk_fixed    <= '0;
      chk_throttle <= '0;
      target       <= '0;
      tmo_limit    <= '0;
      arm_cnt      <= '0;
      drain_cnt    <= 1'b0;
      idle_cnt     <= '0;
      words_seen   <= '0;
      errors       <= '0;
      stat         <= '0;
    end else if (start_ok) begin
      chk_pattern  <= cfg_pattern;
      chk_fixed    <= cfg_fixed;
      chk_throttle <= cfg_throttle;
      target       <= cfg_words;
      tmo_limit    <= cfg_timeout;
      arm_cnt      <= '0;
      drain_cnt    <= 1'b0;
      idle_cnt     <= '0;
      words_seen   <= '0;
      errors       <= '0;
      stat         <= '0;
    end else begin
      arm_cnt   <= (state == ARM) ? arm_cnt + ARM_ONE : '0;
      drain_cnt <= (state == DRAIN && !abort_ok) ? ~drain_cnt : 1'b0;
      if (pipe_in_write && (state == RUN || state == DRAIN)) words_seen <= words_inc;
      if (state == RUN) idle_cnt <= pipe_in_write ? '0 : idle_inc;
      if (abort_ok)     stat.aborted <= 1'b1;
      else if (tmo_hit) stat.timeout <= 1'b1;
      if (drain_last && !abort_ok) begin
        stat.done <= 1'b1;
        stat.pass <= (chk_error_count == 32'd0) && !stat.timeout && !stat.aborted;
        errors    <= chk_error_count;
      end
    end
  end

endmodule

// File: tb/tb_pipe_in_test_seq.sv
// Self-checking bench for the Pipe In data-check sequencer: a table of runs
// pushed through a result scoreboard, plus hand sequences for latency,
// configuration capture, exact timeout, and asynchronous reset.
module tb_pipe_in_test_seq;

  localparam int CNT_W   = 32;
  localparam int TMO_W   = 24;
  localparam int RST_CYC = 4;

  logic             clk;
  logic             reset;
  logic             start;
  logic             abort;
  logic [2:0]       cfg_pattern;
  logic [31:0]      cfg_fixed;
  logic [31:0]      cfg_throttle;
  logic [CNT_W-1:0] cfg_words;
  logic [TMO_W-1:0] cfg_timeout;
  logic             pipe_in_write;
  logic [31:0]      chk_error_count;
  logic             chk_reset;
  logic             chk_throttle_set;
  logic [2:0]       chk_pattern;
  logic [31:0]      chk_fixed;
  logic [31:0]      chk_throttle;
  logic             busy;
  logic             done;
  logic             pass;
  logic             timeout;
  logic             aborted;
  logic [CNT_W-1:0] words_seen;
  logic [31:0]      errors;

  pipe_in_test_seq #(.CNT_W(CNT_W), .TMO_W(TMO_W), .RST_CYC(RST_CYC)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cfg_pattern(cfg_pattern), .cfg_fixed(cfg_fixed), .cfg_throttle(cfg_throttle),
    .cfg_words(cfg_words), .cfg_timeout(cfg_timeout), .pipe_in_write(pipe_in_write),
    .chk_error_count(chk_error_count), .chk_reset(chk_reset),
    .chk_throttle_set(chk_throttle_set), .chk_pattern(chk_pattern),
    .chk_fixed(chk_fixed), .chk_throttle(chk_throttle), .busy(busy), .done(done),
    .pass(pass), .timeout(timeout), .aborted(aborted), .words_seen(words_seen),
    .errors(errors)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] words;
    logic [23:0] tmo;
    int          nwr;
    int          abort_at;
    logic [31:0] err;
    logic [31:0] exp_words;
    logic [31:0] exp_errors;
    logic        exp_pass;
    logic        exp_tmo;
    logic        exp_abort;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [31:0] words;
    logic [31:0] errors;
    logic        pass;
    logic        tmo;
    logic        abort;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[7];
  int   chk_cnt = 0;
  int   err_cnt = 0;
  int   lat;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    chk_cnt++;
    if (act !== req) begin
      err_cnt++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic pushExp(input logic [31:0] w, input logic [31:0] e, input logic p,
                         input logic t, input logic a);
    exp_t x;
    x.words = w; x.errors = e; x.pass = p; x.tmo = t; x.abort = a;
    sb.push_back(x);
  endtask

  // Starts a run from the table, drives the writes (with an optional abort on
  // one of them) and leaves the checker's error count at the run's value.
  task automatic applyStimulus(input vec_t v);
    pushExp(v.exp_words, v.exp_errors, v.exp_pass, v.exp_tmo, v.exp_abort);
    cfg_words       = v.words;
    cfg_timeout     = v.tmo;
    chk_error_count = 32'd0;
    start           = 1'b1;
    step();
    start = 1'b0;
    repeat (RST_CYC) step();
    for (int i = 1; i <= v.nwr; i++) begin
      pipe_in_write = 1'b1;
      abort         = (i == v.abort_at);
      step();
    end
    pipe_in_write   = 1'b0;
    abort           = 1'b0;
    chk_error_count = v.err;
  endtask

  // Bounded wait for done, then pops the oldest expected result and compares.
  task automatic waitDone(input string tag, output int cnt);
    exp_t e;
    cnt = 0;
    while (done !== 1'b1 && cnt < 3000) begin
      step();
      cnt++;
    end
    if (done !== 1'b1) begin
      checkOutput($sformatf("%s.done_wait", tag), {63'd0, done}, 64'd1);
      if (sb.size() > 0) e = sb.pop_front();
    end else if (sb.size() == 0) begin
      checkOutput($sformatf("%s.sb_empty", tag), 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      checkOutput($sformatf("%s.words_seen", tag), words_seen, e.words);
      checkOutput($sformatf("%s.errors", tag), errors, e.errors);
      checkOutput($sformatf("%s.pass", tag), pass, e.pass);
      checkOutput($sformatf("%s.timeout", tag), timeout, e.tmo);
      checkOutput($sformatf("%s.aborted", tag), aborted, e.abort);
      checkOutput($sformatf("%s.busy", tag), busy, 1'b0);
      checkOutput($sformatf("%s.chk_reset", tag), chk_reset, 1'b0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; pipe_in_write = 1'b0;
    cfg_pattern = 3'd0; cfg_fixed = 32'd0; cfg_throttle = 32'd0;
    cfg_words = '0; cfg_timeout = '0; chk_error_count = 32'd0;
    repeat (3) step();
    checkOutput("rst.chk_reset", chk_reset, 1'b1);
    checkOutput("rst.busy", busy, 1'b0);
    checkOutput("rst.done", done, 1'b0);
    checkOutput("rst.words_seen", words_seen, 0);
    checkOutput("rst.chk_throttle_set", chk_throttle_set, 1'b0);
    reset = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    checkOutput("idle_abort.aborted", aborted, 1'b0);
    checkOutput("idle_abort.busy", busy, 1'b0);

    // words, tmo, nwr, abort_at, err, exp_words, exp_errors, pass, tmo, abort, lat
    vecs[0] = '{32'd16,   24'd0,   16, 0,  32'd0, 32'd16, 32'd0, 1'b1, 1'b0, 1'b0, 3};
    vecs[1] = '{32'd8,    24'd0,   8,  0,  32'd3, 32'd8,  32'd3, 1'b0, 1'b0, 1'b0, 3};
    vecs[2] = '{32'd50,   24'd100, 5,  0,  32'd0, 32'd5,  32'd0, 1'b0, 1'b1, 1'b0, 103};
    vecs[3] = '{32'd1000, 24'd0,   11, 11, 32'd0, 32'd11, 32'd0, 1'b0, 1'b0, 1'b1, 3};
    vecs[4] = '{32'd0,    24'd0,   0,  0,  32'd0, 32'd0,  32'd0, 1'b1, 1'b0, 1'b0, 0};
    vecs[5] = '{32'd1,    24'd0,   1,  0,  32'd0, 32'd1,  32'd0, 1'b1, 1'b0, 1'b0, 3};
    vecs[6] = '{32'd3,    24'd4,   3,  0,  32'd0, 32'd3,  32'd0, 1'b1, 1'b0, 1'b0, 3};

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i]);
      waitDone($sformatf("vec%0d", i), lat);
      if (vecs[i].exp_lat != 0)
        checkOutput($sformatf("vec%0d.latency", i), lat + 1, vecs[i].exp_lat);
    end

    // Start and abort together from DONE, ARM timing, config capture, and a
    // start pulse in RUN that must be ignored.
    cfg_words = 32'd6; cfg_timeout = '0; cfg_pattern = 3'd5;
    cfg_fixed = 32'hA5A5_0001; cfg_throttle = 32'h0000_00F0; chk_error_count = 32'd0;
    pushExp(32'd6, 32'd0, 1'b1, 1'b0, 1'b0);
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    checkOutput("seqA.aborted", aborted, 1'b0);
    checkOutput("seqA.done_cleared", done, 1'b0);
    checkOutput("seqA.chk_pattern", chk_pattern, 3'd5);
    checkOutput("seqA.chk_fixed", chk_fixed, 32'hA5A5_0001);
    checkOutput("seqA.chk_throttle", chk_throttle, 32'h0000_00F0);
    for (int i = 1; i <= RST_CYC; i++) begin
      checkOutput($sformatf("seqA.arm%0d.chk_reset", i), chk_reset, 1'b1);
      checkOutput($sformatf("seqA.arm%0d.throttle_set", i), chk_throttle_set, (i == RST_CYC));
      step();
    end
    checkOutput("seqA.run.chk_reset", chk_reset, 1'b0);
    checkOutput("seqA.run.busy", busy, 1'b1);
    cfg_pattern = 3'd0; cfg_fixed = 32'd0; cfg_throttle = 32'd0; cfg_words = 32'd1;
    repeat (3) begin pipe_in_write = 1'b1; step(); end
    pipe_in_write = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    checkOutput("seqA.start_ignored.busy", busy, 1'b1);
    checkOutput("seqA.start_ignored.words", words_seen, 3);
    checkOutput("seqA.cfg_hold.pattern", chk_pattern, 3'd5);
    checkOutput("seqA.cfg_hold.fixed", chk_fixed, 32'hA5A5_0001);
    repeat (3) begin pipe_in_write = 1'b1; step(); end
    pipe_in_write = 1'b0;
    waitDone("seqA", lat);
    checkOutput("seqA.latency", lat + 1, 3);

    // Timeout lands on the edge closing the tenth idle cycle, not before.
    cfg_words = 32'd20; cfg_timeout = 24'd10;
    pushExp(32'd2, 32'd0, 1'b0, 1'b1, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (RST_CYC) step();
    repeat (2) begin pipe_in_write = 1'b1; step(); end
    pipe_in_write = 1'b0;
    repeat (9) step();
    checkOutput("seqB.tmo_early", timeout, 1'b0);
    checkOutput("seqB.busy_early", busy, 1'b1);
    step();
    checkOutput("seqB.tmo_exact", timeout, 1'b1);
    waitDone("seqB", lat);

    // Asynchronous reset mid-RUN, then a fresh run re-latches configuration.
    cfg_words = 32'd100; cfg_timeout = '0; cfg_pattern = 3'd2;
    cfg_fixed = 32'h0000_1234; cfg_throttle = 32'd7;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (RST_CYC) step();
    repeat (5) begin pipe_in_write = 1'b1; step(); end
    pipe_in_write = 1'b0;
    checkOutput("seqC.pre_reset.words", words_seen, 5);
    #2 reset = 1'b1;
    #1;
    checkOutput("seqC.async.chk_reset", chk_reset, 1'b1);
    checkOutput("seqC.async.busy", busy, 1'b0);
    checkOutput("seqC.async.words", words_seen, 0);
    checkOutput("seqC.async.pattern", chk_pattern, 3'd0);
    checkOutput("seqC.async.fixed", chk_fixed, 32'd0);
    checkOutput("seqC.async.throttle", chk_throttle, 32'd0);
    step();
    reset = 1'b0;
    cfg_words = 32'd2; cfg_pattern = 3'd6; cfg_fixed = 32'hCAFE_0002; cfg_throttle = 32'h10;
    pushExp(32'd2, 32'd0, 1'b1, 1'b0, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    checkOutput("seqC.relatch.pattern", chk_pattern, 3'd6);
    checkOutput("seqC.relatch.fixed", chk_fixed, 32'hCAFE_0002);
    repeat (RST_CYC) step();
    repeat (2) begin pipe_in_write = 1'b1; step(); end
    pipe_in_write = 1'b0;
    waitDone("seqC", lat);
    checkOutput("seqC.latency", lat + 1, 3);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
